// File: rtl/muldiv_pkg.sv
// Shared op codes and FSM state encodings for the mul/div sequencer.
// The decode stage imports the same op codes so both sides agree on encoding.
package muldiv_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_MULT  = 3'b000;
  localparam md_op_t MD_MULTU = 3'b001;
  localparam md_op_t MD_DIV   = 3'b010;
  localparam md_op_t MD_DIVU  = 3'b011;
  localparam md_op_t MD_MTHI  = 3'b100;
  localparam md_op_t MD_MTLO  = 3'b101;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Ops 000..011 run through the iterative datapath; bit 1 selects divide, bit 0 unsigned.
  function automatic logic is_muldiv(input md_op_t op);
    return op[2] == 1'b0;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Issue/result bundle between decode stage (master) and mul/div sequencer (slave).
// The div0 signal exists only when MULDIV_DIV0_FLAG_EN is defined.
interface muldiv_seq_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  md_op_t           op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIV0_FLAG_EN
  logic             div0;

  modport master (output start, op, rs_val, rt_val, flush,
                  input  busy, done, hi, lo, div0);
  modport slave  (input  start, op, rs_val, rt_val, flush,
                  output busy, done, hi, lo, div0);
`else
  modport master (output start, op, rs_val, rt_val, flush,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, rs_val, rt_val, flush,
                  output busy, done, hi, lo);
`endif
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
// Accumulator layout is {upper[WIDTH:0], lower[WIDTH-1:0]}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  acc_i,
  input  logic [WIDTH-1:0]  opnd_i,
  input  logic              is_div_i,
  output logic [2*WIDTH:0]  acc_o
);
  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shl;
  logic [WIDTH+1:0] diff;

  always_comb begin
    sum  = acc_i[2*WIDTH:WIDTH] + {1'b0, opnd_i};
    shl  = {acc_i[2*WIDTH-1:0], 1'b0};
    diff = {1'b0, shl[2*WIDTH:WIDTH]} - {2'b00, opnd_i};
    if (is_div_i) begin
      // Keep the trial difference only when it did not go negative.
      if (!diff[WIDTH+1]) acc_o = {diff[WIDTH:0], shl[WIDTH-1:1], 1'b1};
      else                acc_o = shl;
    end else if (acc_i[0]) begin
      acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[2*WIDTH:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; MTHI/MTLO write HI/LO directly.
// Define MULDIV_DIV0_FLAG_EN to add the sticky div0 output.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_seq_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int ACC_W = 2 * WIDTH + 1;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   opnd_q, opnd_d, rs_q, rs_d, rt_q, rt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, sgn_q, sgn_d, dz_q, dz_d;
  logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   rs_abs, rt_abs, quo, rem;
  logic [2*WIDTH-1:0] prod;
  logic               accept_md, commit;

  function automatic logic [WIDTH-1:0] neg_if(input logic c, input logic [WIDTH-1:0] v);
    return c ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic c, input logic [2*WIDTH-1:0] v);
    return c ? -v : v;
  endfunction

  assign accept_md = (state_q == S_IDLE) && bus.start && !bus.flush && is_muldiv(bus.op);
  assign commit    = (state_q == S_FIX) && !bus.flush;

  assign rs_abs = neg_if(sgn_q & rs_q[WIDTH-1], rs_q);
  assign rt_abs = neg_if(sgn_q & rt_q[WIDTH-1], rt_q);
  // A zero divisor leaves the dividend in the remainder half, so only LO needs forcing.
  assign quo    = dz_q ? '1 : neg_if(neg_quo_q, acc_q[WIDTH-1:0]);
  assign rem    = neg_if(neg_rem_q, acc_q[2*WIDTH-1:WIDTH]);
  assign prod   = neg2_if(neg_quo_q, acc_q[2*WIDTH-1:0]);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (acc_step)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    sgn_d     = sgn_q;
    dz_d      = dz_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      S_IDLE: begin
        if (accept_md) begin
          state_d  = S_PREP;
          rs_d     = bus.rs_val;
          rt_d     = bus.rt_val;
          is_div_d = bus.op[1];
          sgn_d    = !bus.op[0];
        end else if (bus.start && !bus.flush && bus.op == MD_MTHI) begin
          hi_d = bus.rs_val;
        end else if (bus.start && !bus.flush && bus.op == MD_MTLO) begin
          lo_d = bus.rs_val;
        end
      end
      S_PREP: begin
        neg_quo_d = sgn_q & (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
        neg_rem_d = sgn_q & rs_q[WIDTH-1];
        dz_d      = (rt_q == '0);
        acc_d     = {{(WIDTH+1){1'b0}}, (is_div_q ? rs_abs : rt_abs)};
        opnd_d    = is_div_q ? rt_abs : rs_abs;
        cnt_d     = CNT_W'(WIDTH - 1);
        state_d   = S_CALC;
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (commit) begin
          if (is_div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      sgn_q     <= 1'b0;
      dz_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      sgn_q     <= sgn_d;
      dz_q      <= dz_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

`ifdef MULDIV_DIV0_FLAG_EN
  logic div0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    div0_q <= 1'b0;
    else if (accept_md)            div0_q <= 1'b0;
    else if (commit && is_div_q)   div0_q <= dz_q;
  end

  assign bus.div0 = div0_q;
`endif

endmodule
